// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : watch_pkg
// Purpose  : Field widths, set_data layout and month constants for the
//            watch calendar.
// Revision : 1.0 - initial release
// ============================================================================
package watch_pkg;

  localparam int MON_W  = 4;
  localparam int DAY_W  = 5;
  localparam int HR_W   = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int WDAY_W = 3;

  // set_data bit positions; the top RSVD_W bits above wday are reserved
  localparam int SEC_LSB  = 0;
  localparam int MIN_LSB  = SEC_LSB + SEC_W;
  localparam int HR_LSB   = MIN_LSB + MIN_W;
  localparam int DAY_LSB  = HR_LSB + HR_W;
  localparam int MON_LSB  = DAY_LSB + DAY_W;
  localparam int YEAR_LSB = MON_LSB + MON_W;
  localparam int RSVD_W   = 6;

  localparam logic [MON_W-1:0] MON_JAN = 4'd1;
  localparam logic [MON_W-1:0] MON_FEB = 4'd2;
  localparam logic [MON_W-1:0] MON_MAR = 4'd3;
  localparam logic [MON_W-1:0] MON_APR = 4'd4;
  localparam logic [MON_W-1:0] MON_MAY = 4'd5;
  localparam logic [MON_W-1:0] MON_JUN = 4'd6;
  localparam logic [MON_W-1:0] MON_JUL = 4'd7;
  localparam logic [MON_W-1:0] MON_AUG = 4'd8;
  localparam logic [MON_W-1:0] MON_SEP = 4'd9;
  localparam logic [MON_W-1:0] MON_OCT = 4'd10;
  localparam logic [MON_W-1:0] MON_NOV = 4'd11;
  localparam logic [MON_W-1:0] MON_DEC = 4'd12;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HR_W-1:0]   HR_MAX   = 5'd23;
  localparam logic [WDAY_W-1:0] WDAY_MAX = 3'd6;

  function automatic int set_w(input int year_w);
    return year_w + 35;
  endfunction

endpackage
`default_nettype wire

// File: rtl/watch_days_in_month.sv
`default_nettype none
// ============================================================================
// Module   : watch_days_in_month
// Purpose  : Combinational days-in-month lookup with optional Gregorian leap.
// Revision : 1.0 - initial release
// ============================================================================
module watch_days_in_month
  import watch_pkg::*;
#(
  parameter int YEAR_W  = 12,
  parameter bit LEAP_EN = 1'b1
) (
  input  logic [MON_W-1:0]  month,
  input  logic [YEAR_W-1:0] year,
  output logic [DAY_W-1:0]  dim
);

  logic [31:0] w_y;
  logic        w_leap;

  assign w_y    = 32'(year);
  assign w_leap = LEAP_EN && (w_y % 32'd4 == 32'd0) &&
                  ((w_y % 32'd100 != 32'd0) || (w_y % 32'd400 == 32'd0));

  always_comb begin
    dim = 5'd0;
    case (month)
      MON_JAN, MON_MAR, MON_MAY, MON_JUL,
      MON_AUG, MON_OCT, MON_DEC: dim = 5'd31;
      MON_APR, MON_JUN, MON_SEP, MON_NOV: dim = 5'd30;
      MON_FEB: dim = w_leap ? 5'd29 : 5'd28;
      default: dim = 5'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/watch_calendar_leap.sv
`default_nettype none
// ============================================================================
// Module   : watch_calendar_leap
// Purpose  : Real-time calendar counter (sec..year, weekday) with validated
//            set handshake and registered rollover pulses.
// Revision : 1.0 - initial release
// ============================================================================
module watch_calendar_leap
  import watch_pkg::*;
#(
  parameter int YEAR_W   = 12,
  parameter int RST_YEAR = 2000,
  parameter int RST_WDAY = 6,
  parameter bit LEAP_EN  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      set_valid,
  input  logic [set_w(YEAR_W)-1:0]  set_data,
  output logic                      set_ack,
  output logic                      set_err,
  output logic [YEAR_W-1:0]         year,
  output logic [MON_W-1:0]          month,
  output logic [DAY_W-1:0]          day,
  output logic [HR_W-1:0]           hour,
  output logic [MIN_W-1:0]          minute,
  output logic [SEC_W-1:0]          second,
  output logic [WDAY_W-1:0]         weekday,
  output logic                      day_tick,
  output logic                      year_wrap
);

  localparam int c_set_w = set_w(YEAR_W);

  logic [YEAR_W-1:0] r_year;
  logic [MON_W-1:0]  r_month;
  logic [DAY_W-1:0]  r_day;
  logic [HR_W-1:0]   r_hour;
  logic [MIN_W-1:0]  r_min;
  logic [SEC_W-1:0]  r_sec;
  logic [WDAY_W-1:0] r_wday;
  logic              r_set_ack, r_set_err, r_day_tick, r_year_wrap;

  logic [YEAR_W-1:0] w_set_year;
  logic [MON_W-1:0]  w_set_mon;
  logic [DAY_W-1:0]  w_set_day;
  logic [HR_W-1:0]   w_set_hr;
  logic [MIN_W-1:0]  w_set_min;
  logic [SEC_W-1:0]  w_set_sec;
  logic [WDAY_W-1:0] w_set_wday;
  logic              w_unused_rsvd;
  logic [DAY_W-1:0]  w_dim_cur, w_dim_set;
  logic              w_set_ok;
  logic              w_adv, w_sec_carry, w_min_carry, w_day_carry;
  logic              w_month_carry, w_year_carry, w_year_wrap;

  assign w_set_sec     = set_data[SEC_LSB +: SEC_W];
  assign w_set_min     = set_data[MIN_LSB +: MIN_W];
  assign w_set_hr      = set_data[HR_LSB +: HR_W];
  assign w_set_day     = set_data[DAY_LSB +: DAY_W];
  assign w_set_mon     = set_data[MON_LSB +: MON_W];
  assign w_set_year    = set_data[YEAR_LSB +: YEAR_W];
  assign w_set_wday    = set_data[YEAR_LSB + YEAR_W +: WDAY_W];
  assign w_unused_rsvd = ^set_data[c_set_w-1 -: RSVD_W];

  watch_days_in_month #(.YEAR_W(YEAR_W), .LEAP_EN(LEAP_EN)) u_dim_cur (
    .month (r_month),
    .year  (r_year),
    .dim   (w_dim_cur)
  );

  watch_days_in_month #(.YEAR_W(YEAR_W), .LEAP_EN(LEAP_EN)) u_dim_set (
    .month (w_set_mon),
    .year  (w_set_year),
    .dim   (w_dim_set)
  );

  // An illegal month yields dim=0, so the day check rejects it as well
  assign w_set_ok = (w_set_mon >= MON_JAN) && (w_set_mon <= MON_DEC) &&
                    (w_set_day != 5'd0) && (w_set_day <= w_dim_set) &&
                    (w_set_hr <= HR_MAX) && (w_set_min <= MIN_MAX) &&
                    (w_set_sec <= SEC_MAX) && (w_set_wday <= WDAY_MAX);

  // A set in the same cycle always swallows the tick
  assign w_adv         = tick & ~set_valid;
  assign w_sec_carry   = w_adv & (r_sec == SEC_MAX);
  assign w_min_carry   = w_sec_carry & (r_min == MIN_MAX);
  assign w_day_carry   = w_min_carry & (r_hour == HR_MAX);
  assign w_month_carry = w_day_carry & (r_day >= w_dim_cur);
  assign w_year_carry  = w_month_carry & (r_month == MON_DEC);
  assign w_year_wrap   = w_year_carry & (r_year == {YEAR_W{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_year  <= YEAR_W'(RST_YEAR);
      r_month <= MON_JAN;
      r_day   <= 5'd1;
      r_hour  <= '0;
      r_min   <= '0;
      r_sec   <= '0;
      r_wday  <= WDAY_W'(RST_WDAY);
    end else if (set_valid) begin
      if (w_set_ok) begin
        r_year  <= w_set_year;
        r_month <= w_set_mon;
        r_day   <= w_set_day;
        r_hour  <= w_set_hr;
        r_min   <= w_set_min;
        r_sec   <= w_set_sec;
        r_wday  <= w_set_wday;
      end
    end else if (tick) begin
      r_sec <= w_sec_carry ? '0 : r_sec + 6'd1;
      if (w_sec_carry) r_min  <= w_min_carry ? '0 : r_min + 6'd1;
      if (w_min_carry) r_hour <= w_day_carry ? '0 : r_hour + 5'd1;
      if (w_day_carry) begin
        r_day  <= w_month_carry ? 5'd1 : r_day + 5'd1;
        r_wday <= (r_wday == WDAY_MAX) ? '0 : r_wday + 3'd1;
      end
      if (w_month_carry) r_month <= w_year_carry ? MON_JAN : r_month + 4'd1;
      if (w_year_carry)  r_year  <= r_year + YEAR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_set_ack   <= 1'b0;
      r_set_err   <= 1'b0;
      r_day_tick  <= 1'b0;
      r_year_wrap <= 1'b0;
    end else begin
      r_set_ack   <= set_valid & w_set_ok;
      r_set_err   <= set_valid & ~w_set_ok;
      r_day_tick  <= w_day_carry;
      r_year_wrap <= w_year_wrap;
    end
  end

  assign year      = r_year;
  assign month     = r_month;
  assign day       = r_day;
  assign hour      = r_hour;
  assign minute    = r_min;
  assign second    = r_sec;
  assign weekday   = r_wday;
  assign set_ack   = r_set_ack;
  assign set_err   = r_set_err;
  assign day_tick  = r_day_tick;
  assign year_wrap = r_year_wrap;

endmodule
`default_nettype wire

// File: tb/tb_watch_calendar_leap.sv
`default_nettype none
// ============================================================================
// Module   : tb_watch_calendar_leap
// Purpose  : Directed vector bench for watch_calendar_leap (leap and no-leap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_watch_calendar_leap;
  import watch_pkg::*;

  localparam int YW = 12;
  localparam int SW = YW + 35;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          set_valid = 1'b0;
  logic [SW-1:0] set_data = '0;

  logic          set_ack, set_err, day_tick, year_wrap;
  logic [YW-1:0] year;
  logic [3:0]    month;
  logic [4:0]    day, hour;
  logic [5:0]    minute, second;
  logic [2:0]    weekday;

  logic          n_set_ack, n_set_err, n_day_tick, n_year_wrap;
  logic [YW-1:0] n_year;
  logic [3:0]    n_month;
  logic [4:0]    n_day, n_hour;
  logic [5:0]    n_minute, n_second;
  logic [2:0]    n_weekday;

  always #5 clk = ~clk;

  watch_calendar_leap #(.YEAR_W(YW), .RST_YEAR(2000), .RST_WDAY(6), .LEAP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .set_valid(set_valid), .set_data(set_data),
    .set_ack(set_ack), .set_err(set_err), .year(year), .month(month), .day(day),
    .hour(hour), .minute(minute), .second(second), .weekday(weekday),
    .day_tick(day_tick), .year_wrap(year_wrap)
  );

  watch_calendar_leap #(.YEAR_W(YW), .RST_YEAR(2000), .RST_WDAY(6), .LEAP_EN(1'b0)) dut_nl (
    .clk(clk), .rst(rst), .tick(tick), .set_valid(set_valid), .set_data(set_data),
    .set_ack(n_set_ack), .set_err(n_set_err), .year(n_year), .month(n_month), .day(n_day),
    .hour(n_hour), .minute(n_minute), .second(n_second), .weekday(n_weekday),
    .day_tick(n_day_tick), .year_wrap(n_year_wrap)
  );

  typedef struct packed {
    logic [YW-1:0] year;
    logic [3:0]    month;
    logic [4:0]    day;
    logic [4:0]    hour;
    logic [5:0]    minute;
    logic [5:0]    second;
    logic [2:0]    wday;
    logic          ack, err, dtick, ywrap;
  } obs_t;

  typedef struct {
    logic          sv;
    logic          tk;
    logic [SW-1:0] data;
    obs_t          exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [SW-1:0] sd(int w, int y, int mo, int d, int h, int mi, int s);
    return {6'd0, 3'(w), 12'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
  endfunction

  function automatic obs_t eo(int y, int mo, int d, int h, int mi, int s, int w,
                              bit ack, bit err, bit dt, bit yw);
    obs_t o;
    o.year = 12'(y); o.month = 4'(mo); o.day = 5'(d); o.hour = 5'(h);
    o.minute = 6'(mi); o.second = 6'(s); o.wday = 3'(w);
    o.ack = ack; o.err = err; o.dtick = dt; o.ywrap = yw;
    return o;
  endfunction

  function automatic vec_t mk(bit sv, bit tk, logic [SW-1:0] d, obs_t e);
    vec_t v;
    v.sv = sv; v.tk = tk; v.data = d; v.exp = e;
    return v;
  endfunction

  function automatic obs_t cur();
    return {year, month, day, hour, minute, second, weekday, set_ack, set_err, day_tick, year_wrap};
  endfunction

  function automatic obs_t cur_nl();
    return {n_year, n_month, n_day, n_hour, n_minute, n_second, n_weekday,
            n_set_ack, n_set_err, n_day_tick, n_year_wrap};
  endfunction

  task automatic check(input string nm, input obs_t a, input obs_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d-%0d-%0d %0d:%0d:%0d w%0d ack=%0b err=%0b dtick=%0b ywrap=%0b, expected %0d-%0d-%0d %0d:%0d:%0d w%0d ack=%0b err=%0b dtick=%0b ywrap=%0b",
               nm, a.year, a.month, a.day, a.hour, a.minute, a.second, a.wday, a.ack, a.err, a.dtick, a.ywrap,
               e.year, e.month, e.day, e.hour, e.minute, e.second, e.wday, e.ack, e.err, e.dtick, e.ywrap);
    end
  endtask

  // Applied at a falling edge, result observed at the next falling edge
  task automatic apply(input bit sv, input bit tk, input logic [SW-1:0] d);
    set_valid = sv; tick = tk; set_data = d;
    @(negedge clk);
    set_valid = 1'b0; tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    obs_t r0;
    r0 = eo(2000, 1, 1, 0, 0, 0, 6, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("reset_active", cur(), r0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      check($sformatf("idle_hold_%0d", i), cur(), r0);
    end

    vecs.push_back(mk(1, 0, sd(3, 2024, 2, 28, 23, 59, 59), eo(2024, 2, 28, 23, 59, 59, 3, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(2024, 2, 29, 0, 0, 0, 4, 0, 0, 1, 0)));
    vecs.push_back(mk(0, 0, '0,                             eo(2024, 2, 29, 0, 0, 0, 4, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 0, sd(0, 2100, 2, 28, 23, 59, 59), eo(2100, 2, 28, 23, 59, 59, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(2100, 3, 1, 0, 0, 0, 1, 0, 0, 1, 0)));
    vecs.push_back(mk(1, 0, sd(0, 2100, 2, 29, 0, 0, 0),    eo(2100, 3, 1, 0, 0, 0, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(1, 0, sd(1, 2000, 2, 28, 23, 59, 59), eo(2000, 2, 28, 23, 59, 59, 1, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(2000, 2, 29, 0, 0, 0, 2, 0, 0, 1, 0)));
    vecs.push_back(mk(1, 0, sd(2, 2000, 2, 29, 23, 59, 59), eo(2000, 2, 29, 23, 59, 59, 2, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(2000, 3, 1, 0, 0, 0, 3, 0, 0, 1, 0)));
    vecs.push_back(mk(1, 0, sd(5, 4095, 12, 31, 23, 59, 59), eo(4095, 12, 31, 23, 59, 59, 5, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(0, 1, 1, 0, 0, 0, 6, 0, 0, 1, 1)));
    vecs.push_back(mk(1, 0, sd(3, 2023, 2, 29, 12, 0, 0),   eo(0, 1, 1, 0, 0, 0, 6, 0, 1, 0, 0)));
    vecs.push_back(mk(1, 0, sd(3, 2023, 13, 1, 12, 0, 0),   eo(0, 1, 1, 0, 0, 0, 6, 0, 1, 0, 0)));
    vecs.push_back(mk(1, 0, sd(3, 2023, 6, 1, 24, 0, 0),    eo(0, 1, 1, 0, 0, 0, 6, 0, 1, 0, 0)));
    vecs.push_back(mk(1, 0, sd(3, 2023, 6, 1, 12, 60, 0),   eo(0, 1, 1, 0, 0, 0, 6, 0, 1, 0, 0)));
    vecs.push_back(mk(1, 0, sd(3, 2023, 6, 1, 12, 0, 60),   eo(0, 1, 1, 0, 0, 0, 6, 0, 1, 0, 0)));
    vecs.push_back(mk(1, 0, sd(7, 2023, 6, 1, 12, 0, 0),    eo(0, 1, 1, 0, 0, 0, 6, 0, 1, 0, 0)));
    vecs.push_back(mk(1, 0, sd(3, 2023, 6, 0, 12, 0, 0),    eo(0, 1, 1, 0, 0, 0, 6, 0, 1, 0, 0)));
    vecs.push_back(mk(1, 0, sd(3, 2023, 0, 1, 12, 0, 0),    eo(0, 1, 1, 0, 0, 0, 6, 0, 1, 0, 0)));
    vecs.push_back(mk(1, 0, sd(3, 2023, 4, 31, 12, 0, 0),   eo(0, 1, 1, 0, 0, 0, 6, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(0, 1, 1, 0, 0, 1, 6, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 1, sd(4, 2023, 6, 15, 10, 59, 59), eo(2023, 6, 15, 10, 59, 59, 4, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(2023, 6, 15, 11, 0, 0, 4, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 1, sd(4, 2023, 6, 15, 25, 0, 0),   eo(2023, 6, 15, 11, 0, 0, 4, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(2023, 6, 15, 11, 0, 1, 4, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 0, sd(6, 1999, 3, 31, 23, 59, 59), eo(1999, 3, 31, 23, 59, 59, 6, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(1999, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0)));
    vecs.push_back(mk(1, 0, sd(0, 2023, 4, 30, 23, 59, 59), eo(2023, 4, 30, 23, 59, 59, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(2023, 5, 1, 0, 0, 0, 1, 0, 0, 1, 0)));
    vecs.push_back(mk(1, 0, sd(0, 2023, 12, 31, 23, 59, 59), eo(2023, 12, 31, 23, 59, 59, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(2024, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0)));
    vecs.push_back(mk(1, 0, sd(2, 2023, 1, 1, 0, 59, 59),   eo(2023, 1, 1, 0, 59, 59, 2, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(2023, 1, 1, 1, 0, 0, 2, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(2023, 1, 1, 1, 0, 1, 2, 0, 0, 0, 0)));
    vecs.push_back(mk(1, 0, sd(2, 2023, 1, 15, 23, 59, 59), eo(2023, 1, 15, 23, 59, 59, 2, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, '0,                             eo(2023, 1, 16, 0, 0, 0, 3, 0, 0, 1, 0)));
    vecs.push_back(mk(0, 0, '0,                             eo(2023, 1, 16, 0, 0, 0, 3, 0, 0, 0, 0)));

    foreach (vecs[i]) begin
      apply(vecs[i].sv, vecs[i].tk, vecs[i].data);
      check($sformatf("vec%0d", i), cur(), vecs[i].exp);
    end

    // Asynchronous reset mid-run, with a set request in flight
    apply(1, 0, sd(4, 2023, 6, 15, 12, 34, 56));
    check("pre_reset_set", cur(), eo(2023, 6, 15, 12, 34, 56, 4, 1, 0, 0, 0));
    #2;
    rst = 1'b0;
    set_valid = 1'b1;
    set_data = sd(1, 2050, 7, 7, 7, 7, 7);
    #1;
    check("async_reset_immediate", cur(), r0);
    @(negedge clk);
    check("reset_discards_set", cur(), r0);
    rst = 1'b1;
    set_valid = 1'b0;
    @(negedge clk);
    check("after_reset_release", cur(), r0);

    // LEAP_EN=0 instance alongside the leap instance
    apply(1, 0, sd(4, 2024, 2, 29, 0, 0, 0));
    check("leap_accepts_feb29", cur(), eo(2024, 2, 29, 0, 0, 0, 4, 1, 0, 0, 0));
    check("noleap_rejects_feb29", cur_nl(), eo(2000, 1, 1, 0, 0, 0, 6, 0, 1, 0, 0));
    apply(1, 0, sd(3, 2024, 2, 28, 23, 59, 59));
    check("noleap_set", cur_nl(), eo(2024, 2, 28, 23, 59, 59, 3, 1, 0, 0, 0));
    apply(0, 1, '0);
    check("noleap_feb_rollover", cur_nl(), eo(2024, 3, 1, 0, 0, 0, 4, 0, 0, 1, 0));
    check("leap_feb_rollover", cur(), eo(2024, 2, 29, 0, 0, 0, 4, 0, 0, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
